// File: rtl/mandel_ui_pkg.sv
// Shared FSM state type and default auto-repeat timing
// for the button command controller.
package mandel_ui_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } btn_state_t;

  localparam int unsigned DEF_REPEAT_DELAY  = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5_000_000;

  function automatic int unsigned umax(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_filter.sv
// Two-flop synchroniser plus stability counter for one raw
// button; held flips only after 2^(COUNTER_SIZE-1) stable cycles.
module btn_filter #(
  parameter int COUNTER_SIZE = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic held
);

  localparam logic [COUNTER_SIZE-1:0] LAST =
    COUNTER_SIZE'((1 << (COUNTER_SIZE - 1)) - 1);

  logic s1;
  logic s2;
  logic [COUNTER_SIZE-1:0] cnt;

  // Counter runs only while the synchronised level disagrees
  // with held; any bounce back to held restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == held) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        held <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_cmd_ctrl.sv
// Debounced buttons -> valid/ready command stream with optional
// auto-repeat, enabled by defining BUTTON_CMD_AUTO_REPEAT_EN.
module button_cmd_ctrl
  import mandel_ui_pkg::*;
#(
  parameter int          NUM_BTN       = 4,
  parameter int          COUNTER_SIZE  = 19,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         button,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic                       cmd_repeat,
  output logic [NUM_BTN-1:0]         held
);

  localparam int IW = $clog2(NUM_BTN);

  btn_state_t         state;
  btn_state_t         state_n;
  logic [NUM_BTN-1:0] held_q;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] clr;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      id_n;
  logic               any_pend;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_flt
    btn_filter #(
      .COUNTER_SIZE(COUNTER_SIZE)
    ) u_flt (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (button[i]),
      .held (held[i])
    );
  end

  assign rise      = held & ~held_q;
  assign any_pend  = |pending;
  assign cmd_valid = (state == ISSUE);

  always_comb begin
    sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) sel = IW'(i);
    end
  end

`ifdef BUTTON_CMD_AUTO_REPEAT_EN
  localparam int unsigned TMAX = umax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          rep_q;
  logic          rep_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      rep_q <= 1'b0;
    end else begin
      timer <= timer_n;
      rep_q <= rep_n;
    end
  end

  assign cmd_repeat = rep_q;
`else
  assign cmd_repeat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_id  <= '0;
      held_q  <= '0;
      pending <= '0;
    end else begin
      state   <= state_n;
      cmd_id  <= id_n;
      held_q  <= held;
      pending <= (pending & ~clr) | rise;
    end
  end

  always_comb begin
    state_n = state;
    id_n    = cmd_id;
    clr     = '0;
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
    rep_n   = rep_q;
    timer_n = timer;
`endif
    unique case (state)
      IDLE: begin
        if (any_pend) begin
          state_n = ISSUE;
          id_n    = sel;
          clr     = NUM_BTN'(1) << sel;
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
          rep_n   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_n = IDLE;
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
          // A repeat keeps the period already loaded at expiry.
          if (held[cmd_id] && !any_pend) begin
            state_n = HOLD;
            if (!rep_q) timer_n = TW'(REPEAT_DELAY - 1);
          end
`endif
        end
      end
      HOLD: begin
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
        if (!held[cmd_id] || any_pend) begin
          state_n = IDLE;
        end else if (timer <= TW'(1)) begin
          state_n = ISSUE;
          rep_n   = 1'b1;
          timer_n = TW'(REPEAT_PERIOD - 1);
        end else begin
          timer_n = timer - 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Randomised scoreboard bench for button_cmd_ctrl with an
// 8-cycle filter, 20-cycle repeat delay and 10-cycle period.
module tb_button_cmd_ctrl;

  localparam int NB  = 4;
  localparam int CS  = 4;
  localparam int DLY = 20;
  localparam int PER = 10;
  localparam int IW  = 2;
  // Raw release -> FSM sees held low, in cycles.
  localparam int LAT = 11;
`ifdef BUTTON_CMD_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    int id;
    bit rep;
    int gap;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] button;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id;
  logic          cmd_repeat;
  logic [NB-1:0] held;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   acc_count = 0;
  int   last_acc  = 0;
  exp_t q[$];

  button_cmd_ctrl #(
    .NUM_BTN      (NB),
    .COUNTER_SIZE (CS),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_repeat(cmd_repeat),
    .held      (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One press held rel cycles past its acceptance: initial command,
  // then repeats at DLY, DLY+PER, ... while the debounced level lasts.
  task automatic expect_press(input int idx, input int rel);
    int t = DLY;
    int g = DLY;
    q.push_back('{id: idx, rep: 1'b0, gap: 0});
    while (AR && t < rel + LAT) begin
      q.push_back('{id: idx, rep: 1'b1, gap: g});
      t += PER;
      g = PER;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int n, input bit rnd, input string tag);
    int start = acc_count;
    int t = 0;
    while (acc_count < start + n && t < 300) begin
      if (rnd) begin
        @(posedge clk);
        #1 cmd_ready = ($urandom_range(0, 1) != 0);
      end
      @(negedge clk);
      #1;
      t++;
    end
    if (acc_count < start + n) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: accepted %0d, expected %0d",
               tag, acc_count - start, n);
    end
  endtask

  task automatic hold_press(input int idx, input int bcyc, input int bint,
                            input int rel, input string tag);
    int n = 0;
    int k;
    expect_press(idx, rel);
    while (n < bcyc) begin
      button[idx] = ~button[idx];
      k = (bint != 0) ? bint : int'($urandom_range(1, 7));
      tick(k);
      n += k;
    end
    button[idx] = 1'b1;
    wait_accept(1, 1'b0, tag);
    tick(rel);
    button[idx] = 1'b0;
    tick(30);
    chk({"drain_", tag}, q.size(), 0);
  endtask

  task automatic stall_press(input int idx);
    expect_press(idx, 3);
    button[idx] = 1'b1;
    wait_accept(1, 1'b1, "rnd_ready");
    cmd_ready = 1'b1;
    tick(3);
    button[idx] = 1'b0;
    tick(30);
    chk("drain_rnd_ready", q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit stall_prev = 1'b0;
    logic [IW-1:0] pid = '0;
    logic prep = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", int'(cmd_valid), 1);
          chk("stall_id", int'(cmd_id), int'(pid));
          chk("stall_rep", int'(cmd_repeat), int'(prep));
        end
        if (cmd_valid && cmd_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmd: id=%0d rep=%0b, expected none",
                     cmd_id, cmd_repeat);
          end else begin
            e = q.pop_front();
            chk("cmd_id", int'(cmd_id), e.id);
            chk("cmd_repeat", int'(cmd_repeat), int'(e.rep));
            if (e.gap != 0) chk("repeat_gap", cyc - last_acc, e.gap);
          end
          last_acc = cyc;
          acc_count++;
        end
        stall_prev = cmd_valid && !cmd_ready;
        pid        = cmd_id;
        prep       = cmd_repeat;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    button    = '0;
    cmd_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_repeat", int'(cmd_repeat), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_held", int'(held), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Bouncing press, then a clean hold.
    hold_press(2, 30, 3, 28, "bounce");

    // Simultaneous presses behind a stalled consumer.
    cmd_ready = 1'b0;
    q.push_back('{id: 1, rep: 1'b0, gap: 0});
    q.push_back('{id: 3, rep: 1'b0, gap: 0});
    button = 4'b1010;
    tick(50);
    cmd_ready = 1'b1;
    wait_accept(2, 1'b0, "dual");
    tick(3);
    button = '0;
    tick(30);
    chk("drain_dual", q.size(), 0);

    // Long hold: auto-repeat cadence.
    hold_press(0, 0, 0, 44, "long");

    // New press interrupts a hold; old button does not resume.
    q.push_back('{id: 0, rep: 1'b0, gap: 0});
    q.push_back('{id: 2, rep: 1'b0, gap: 0});
    button[0] = 1'b1;
    wait_accept(1, 1'b0, "intr_a");
    tick(3);
    button[2] = 1'b1;
    wait_accept(1, 1'b0, "intr_b");
    tick(2);
    button[2] = 1'b0;
    tick(40);
    button[0] = 1'b0;
    tick(30);
    chk("drain_intr", q.size(), 0);

    for (int r = 0; r < 6; r++) begin
      hold_press($urandom_range(0, NB - 1), $urandom_range(0, 24), 0,
                 10 * $urandom_range(0, 5) + $urandom_range(3, 7), "rnd");
    end
    for (int r = 0; r < 4; r++) begin
      stall_press($urandom_range(0, NB - 1));
    end

    // Reset while a command is on offer, another still pending.
    cmd_ready = 1'b0;
    button    = 4'b0110;
    t = 0;
    while (!cmd_valid && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("mid_issue_valid", int'(cmd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(cmd_valid), 0);
    chk("async_rst_id", int'(cmd_id), 0);
    chk("async_rst_held", int'(held), 0);
    tick(2);
    button = '0;
    tick(3);
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    tick(40);
    chk("drain_rst", q.size(), 0);

    // Button held through reset release counts as one press.
    @(posedge clk);
    #1 rst_n = 1'b0;
    button[3] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    expect_press(3, 3);
    wait_accept(1, 1'b0, "thru_rst");
    tick(3);
    button[3] = 1'b0;
    tick(30);
    chk("drain_thru_rst", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
